// File: rtl/sram_axi_arbiter.sv
// Bridges the instruction-fetch and data SRAM-like ports onto one AXI3 master.
// One read (AR/R) and one write (AW/W/B) may be in flight at the same time.
module sram_axi_arbiter #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_is_data;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [1:0]  w_size;
    logic [3:0]  w_strb;
    logic        aw_pend;
    logic        w_pend;

    logic data_rd, raw_hazard, grant_data, grant_inst, accept_wr;
    logic r_beat, r_beat_data, r_beat_inst, b_done;
    logic unused_inputs;

    assign unused_inputs = ^{rresp, rlast, bid, bresp};

    // A read to the word still being written must wait until B returns.
    assign data_rd     = data_req && !data_wr;
    assign raw_hazard  = (w_state != W_IDLE) && (data_addr[31:2] == w_addr[31:2]);
    assign grant_data  = resetn && (r_state == R_IDLE) && data_rd && !raw_hazard;
    assign grant_inst  = resetn && (r_state == R_IDLE) && inst_req && !grant_data;
    assign accept_wr   = resetn && (w_state == W_IDLE) && data_req && data_wr;

    assign r_beat      = (r_state == R_R) && rvalid;
    assign r_beat_data = r_beat && (rid == ID_DATA);
    assign r_beat_inst = r_beat && (rid == ID_INST);
    // Data read and write response share data_data_ok; the read wins, B waits a cycle.
    assign bready      = (w_state == W_B) && !(r_beat_data && bvalid);
    assign b_done      = bvalid && bready;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data || accept_wr;
    assign inst_data_ok = r_beat_inst;
    assign data_data_ok = r_beat_data || b_done;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = r_is_data ? ID_DATA : ID_INST;
    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_R);
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = ID_DATA;
    assign awaddr  = w_addr;
    assign awsize  = {1'b0, w_size};
    assign awvalid = aw_pend;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = ID_DATA;
    assign wdata   = w_data;
    assign wstrb   = w_strb;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            r_addr    <= 32'd0;
            r_size    <= 2'd0;
            r_is_data <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (grant_data) begin
                        r_addr    <= data_addr;
                        r_size    <= data_size;
                        r_is_data <= 1'b1;
                        r_state   <= R_AR;
                    end else if (grant_inst) begin
                        r_addr    <= inst_addr;
                        r_size    <= inst_size;
                        r_is_data <= 1'b0;
                        r_state   <= R_AR;
                    end
                end
                R_AR:    if (arready) r_state <= R_R;
                R_R:     if (rvalid) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            w_addr  <= 32'd0;
            w_data  <= 32'd0;
            w_size  <= 2'd0;
            w_strb  <= 4'd0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (accept_wr) begin
                        w_addr  <= data_addr;
                        w_data  <= data_wdata;
                        w_size  <= data_size;
                        w_strb  <= data_wstrb;
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                        w_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awready) aw_pend <= 1'b0;
                    if (wready) w_pend <= 1'b0;
                    if ((!aw_pend || awready) && (!w_pend || wready)) w_state <= W_B;
                end
                W_B:     if (b_done) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Scoreboarded bench for sram_axi_arbiter: an AXI slave model with configurable delays
// answers the bridge, expected read data and write payloads are queued at addr_ok.
module tb_sram_axi_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    sram_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic [31:0] iq[$];
    logic [31:0] drq[$];
    wr_t         wq[$];

    int n_chk = 0, n_err = 0;
    int d_ok_cnt = 0;
    int r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    bit r_hold = 0, b_hold = 0;
    int n_aok, n_dok, prev_c, base;
    bit aok_f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rmem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && (iq.size() + drq.size() + wq.size()) != 0; i++) tick();
        chk(tag, iq.size() + drq.size() + wq.size(), 0);
        tick();
    endtask

    // AXI read slave: one outstanding AR, R beat after r_dly cycles unless held.
    initial begin
        logic        ar_hs, r_hs;
        logic [31:0] la;
        logic [3:0]  lid;
        bit          pend;
        int          cnt;
        arready = 1'b1; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
        pend = 0; cnt = 0; la = 32'd0; lid = 4'd0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (ar_hs) begin la = araddr; lid = arid; end
            @(posedge clk);
            #1;
            if (!resetn) begin
                rvalid = 1'b0; pend = 0;
            end else begin
                if (r_hs) rvalid = 1'b0;
                if (ar_hs) begin pend = 1; cnt = r_dly; end
                if (pend && !r_hold) begin
                    if (cnt == 0) begin rvalid = 1'b1; rid = lid; rdata = rmem(la); pend = 0; end
                    else cnt--;
                end
            end
        end
    end

    // AXI write slave: independent AW/W ready delays, B after both handshakes.
    initial begin
        logic aw_hs, w_hs, b_hs;
        bit   aw_seen, w_seen, bpend;
        int   aw_wait, w_wait, bcnt;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
        aw_seen = 0; w_seen = 0; bpend = 0; aw_wait = 0; w_wait = 0; bcnt = 0;
        forever begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            @(posedge clk);
            #1;
            if (!resetn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                aw_seen = 0; w_seen = 0; bpend = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (aw_hs) aw_seen = 1;
                if (w_hs) w_seen = 1;
                if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; bpend = 1; bcnt = b_dly; end
                if (bpend && !b_hold) begin
                    if (bcnt == 0) begin bvalid = 1'b1; bid = 4'd1; bpend = 0; end
                    else bcnt--;
                end
                awready = awvalid && (aw_wait >= aw_dly);
                aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
                wready  = wvalid && (w_wait >= w_dly);
                w_wait  = (wvalid && !wready) ? w_wait + 1 : 0;
            end
        end
    end

    // Scoreboard: pops expected read data / write payloads as the DUT completes them.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (inst_data_ok) begin
                if (iq.size() == 0) chk("inst_ok_spurious", 1, 0);
                else chk("inst_rdata", inst_rdata, iq.pop_front());
            end
            if (data_data_ok) begin
                d_ok_cnt++;
                if (rvalid && rready && rid == 4'd1) begin
                    if (drq.size() == 0) chk("data_rd_spurious", 1, 0);
                    else chk("data_rdata", data_rdata, drq.pop_front());
                end else begin
                    chk("data_ok_on_b", {31'd0, bvalid && bready}, 1);
                    if (wq.size() != 0) void'(wq.pop_front());
                end
            end
            if (awvalid && awready) begin
                if (wq.size() == 0) chk("aw_spurious", 1, 0);
                else begin
                    chk("awaddr", awaddr, wq[0].addr);
                    chk("awid_awsize", {awid, awsize}, {4'd1, 3'd2});
                end
            end
            if (wvalid && wready) begin
                if (wq.size() == 0) chk("w_spurious", 1, 0);
                else begin
                    chk("wdata", wdata, wq[0].data);
                    chk("wstrb_wid_wlast", {wstrb, wid, wlast}, {wq[0].strb, 4'd1, 1'b1});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000;
        data_wstrb = 4'hF; data_wdata = 32'd0;
        #3;
        chk("rst_outs", {arvalid, awvalid, wvalid, rready, bready,
                         inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        chk("axi_ar_consts", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        chk("axi_aw_consts", {awlen, awburst, awlock, awcache, awprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        inst_req = 1'b0; data_req = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        #2; r_dly = 1;

        // Data read beats a simultaneous fetch; fetch granted after R_IDLE returns.
        tick();
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000;
        #2;
        chk("arb_data_aok", data_addr_ok, 1);
        chk("arb_inst_aok", inst_addr_ok, 0);
        drq.push_back(rmem(32'h1000));
        tick(); data_req = 1'b0; #2;
        chk("ar_addr", araddr, 32'h1000);
        chk("ar_id_valid", {arid, arvalid}, {4'd1, 1'b1});
        chk("arb_inst_wait0", inst_addr_ok, 0);
        tick(); #2; chk("arb_inst_wait1", inst_addr_ok, 0);
        tick(); #2;
        chk("arb_data_ok", data_data_ok, 1);
        chk("arb_inst_wait2", inst_addr_ok, 0);
        tick(); #2;
        chk("arb_inst_aok_late", inst_addr_ok, 1);
        iq.push_back(rmem(32'h100));
        tick(); inst_req = 1'b0;
        drain("drain_arb");
        #2; r_dly = 0; aw_dly = 0; w_dly = 3; b_hold = 1;

        // Write with W ready three cycles after AW; B held so the RAW check can follow.
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2004;
        data_wstrb = 4'b0011; data_wdata = 32'hCAFE_F00D;
        #2;
        chk("wr_aok", data_addr_ok, 1);
        wq.push_back('{32'h2004, 32'hCAFE_F00D, 4'b0011});
        tick(); data_req = 1'b0; #2; chk("wr_c0", {awvalid, wvalid, bready}, 3'b110);
        tick(); #2; chk("wr_c1", {awvalid, wvalid, bready}, 3'b010);
        tick(); #2; chk("wr_c2", {awvalid, wvalid, bready}, 3'b010);
        tick(); #2; chk("wr_c3", {awvalid, wvalid, bready}, 3'b010);
        tick(); #2; chk("wr_in_b", {awvalid, wvalid, bready}, 3'b001);

        // Read to the same word is held off; a fetch goes through meanwhile.
        tick();
        inst_req = 1'b1; inst_addr = 32'h300;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h2004;
        #2;
        chk("raw_data_blocked", data_addr_ok, 0);
        chk("raw_inst_aok", inst_addr_ok, 1);
        iq.push_back(rmem(32'h300));
        for (int i = 0; i < 3; i++) begin
            tick(); inst_req = 1'b0; #2;
            chk("raw_hold", data_addr_ok, 0);
        end
        @(negedge clk); #1; b_hold = 0;
        tick(); #2;
        chk("raw_b_cycle_aok", data_addr_ok, 0);
        chk("raw_b_ok", data_data_ok, 1);
        tick(); #2;
        chk("raw_release_aok", data_addr_ok, 1);
        drq.push_back(rmem(32'h2004));
        tick(); data_req = 1'b0;
        drain("drain_raw");
        #2; w_dly = 0; r_hold = 1; b_hold = 1;

        // R beat and B arrive together: read reported first, write one cycle later.
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h3000;
        data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        #2;
        chk("col_wr_aok", data_addr_ok, 1);
        wq.push_back('{32'h3000, 32'h1234_5678, 4'hF});
        tick(); data_wr = 1'b0; data_addr = 32'h4000; #2;
        chk("col_rd_aok", data_addr_ok, 1);
        drq.push_back(rmem(32'h4000));
        tick(); data_req = 1'b0;
        repeat (4) tick();
        @(negedge clk); #1; r_hold = 0; b_hold = 0; base = d_ok_cnt;
        tick(); #2;
        chk("col_bready_low", bready, 0);
        chk("col_ok_read", data_data_ok, 1);
        tick(); #2;
        chk("col_bready_high", bready, 1);
        chk("col_ok_write", data_data_ok, 1);
        tick(); #2;
        chk("col_ok_idle", data_data_ok, 0);
        tick();
        chk("col_pulses", d_ok_cnt - base, 2);
        drain("drain_col");

        // Reset while the R beat is on the bus.
        inst_req = 1'b1; inst_addr = 32'h500; #2;
        chk("rst_mid_aok", inst_addr_ok, 1);
        iq.push_back(rmem(32'h500));
        tick(); inst_req = 1'b0;
        tick(); #1;
        chk("rst_mid_pre_ok", inst_data_ok, 1);
        resetn = 1'b0; #1;
        chk("rst_mid_outs", {arvalid, awvalid, wvalid, rready, bready,
                             inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        iq.delete();
        tick(); tick();
        resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h600; #2;
        chk("rst_first_aok", inst_addr_ok, 1);
        iq.push_back(rmem(32'h600));
        tick(); inst_req = 1'b0;
        drain("drain_rst");

        // Back-to-back fetches: one completion every three cycles.
        inst_req = 1'b1; inst_addr = 32'h8000;
        n_aok = 0; n_dok = 0; prev_c = -1;
        for (int c = 0; c < 12; c++) begin
            #2;
            aok_f = inst_addr_ok;
            if (aok_f) begin iq.push_back(rmem(inst_addr)); n_aok++; end
            if (inst_data_ok) begin
                if (prev_c >= 0) chk("b2b_gap", c - prev_c, 3);
                prev_c = c; n_dok++;
            end
            if (arvalid) chk("b2b_ar_fields", {arid, arsize, arlen}, {4'd0, 3'd2, 8'd0});
            tick();
            if (aok_f) inst_addr = inst_addr + 32'd4;
        end
        inst_req = 1'b0;
        chk("b2b_aok_count", n_aok, 4);
        chk("b2b_dok_count", n_dok, 4);
        drain("drain_b2b");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
